// File: rtl/regfile_if.sv
// Register file access bus: one write port and two combinational read ports.
// The master (decode/writeback side) drives addresses and write data; the slave returns read data.
interface regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile.sv
// 32-entry integer register file: two combinational read ports, one synchronous write port.
// x0 reads as zero and ignores writes; optional same-cycle write-to-read bypass.
module regfile #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREGS        = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned WRITE_BYPASS = 0
) (
    input logic      clk,
    input logic      rst_n,
    regfile_if.slave bus
);
    localparam bit Bypass = (WRITE_BYPASS != 0);

    if (AW != $clog2(NREGS)) begin : g_bad_aw
        $error("regfile: AW must equal log2(NREGS)");
    end
    if ((NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile: NREGS must be a power of two");
    end

    logic [XLEN-1:0] regs_q [NREGS];

    // Entry 0 is only ever reset, so it stays zero; reads also force zero for address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.we && (bus.waddr != '0)) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        bus.rdata1 = '0;
        if (rst_n && (bus.raddr1 != '0)) begin
            bus.rdata1 = regs_q[bus.raddr1];
            if (Bypass && bus.we && (bus.waddr == bus.raddr1)) begin
                bus.rdata1 = bus.wdata;
            end
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (rst_n && (bus.raddr2 != '0)) begin
            bus.rdata2 = regs_q[bus.raddr2];
            if (Bypass && bus.we && (bus.waddr == bus.raddr2)) begin
                bus.rdata2 = bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: drives a non-bypass and a bypass instance with identical
// stimulus and compares both against an array-based reference model.
module tb_regfile;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            we = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [AW-1:0]   raddr1 = '0;
    logic [AW-1:0]   raddr2 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] model [32];

    always #5 clk = ~clk;

    regfile_if #(.XLEN(XLEN), .AW(AW)) bus0 ();
    regfile_if #(.XLEN(XLEN), .AW(AW)) bus1 ();

    assign bus0.we = we;
    assign bus0.waddr = waddr;
    assign bus0.wdata = wdata;
    assign bus0.raddr1 = raddr1;
    assign bus0.raddr2 = raddr2;
    assign bus1.we = we;
    assign bus1.waddr = waddr;
    assign bus1.wdata = wdata;
    assign bus1.raddr1 = raddr1;
    assign bus1.raddr2 = raddr2;

    regfile #(.XLEN(XLEN), .NREGS(32), .AW(AW), .WRITE_BYPASS(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    regfile #(.XLEN(XLEN), .NREGS(32), .AW(AW), .WRITE_BYPASS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic            we;
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
        logic [AW-1:0]   raddr1;
        logic [AW-1:0]   raddr2;
        logic [XLEN-1:0] exp1;
        logic [XLEN-1:0] exp2;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [XLEN-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
        if (!rst_n || a == '0) return '0;
        if (byp && we && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name);
        check({name, " dut0.rdata1"}, bus0.rdata1, exp_rd(1'b0, raddr1));
        check({name, " dut0.rdata2"}, bus0.rdata2, exp_rd(1'b0, raddr2));
        check({name, " dut1.rdata1"}, bus1.rdata1, exp_rd(1'b1, raddr1));
        check({name, " dut1.rdata2"}, bus1.rdata2, exp_rd(1'b1, raddr2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Advance one rising edge and apply the architectural write rule to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n && we && waddr != '0) model[waddr] = wdata;
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'd123,        5'd5,  5'd0,  32'd123,        32'd0};
        vecs[1] = '{1'b1, 5'd0,  32'd999,        5'd0,  5'd0,  32'd0,          32'd0};
        vecs[2] = '{1'b1, 5'd3,  32'hDEADBEEF,   5'd3,  5'd5,  32'hDEADBEEF,   32'd123};
        vecs[3] = '{1'b1, 5'd31, 32'h00000001,   5'd3,  5'd31, 32'hDEADBEEF,   32'h1};
        vecs[4] = '{1'b0, 5'd0,  32'd0,          5'd31, 5'd3,  32'h1,          32'hDEADBEEF};
        vecs[5] = '{1'b1, 5'd7,  32'd42,         5'd7,  5'd0,  32'd42,         32'd0};
        vecs[6] = '{1'b0, 5'd7,  32'd55,         5'd7,  5'd7,  32'd42,         32'd42};
        vecs[7] = '{1'b1, 5'd7,  32'd55,         5'd7,  5'd5,  32'd55,         32'd123};

        clear_model();
        #2 rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a += 9) begin
            drive(1'b0, '0, '0, AW'(a), AW'(31 - a));
            #1 check_all("reset read");
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Write/readback, x0, dual-port, write-enable gating.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2);
            tick();
            we = 1'b0;
            #1;
            check($sformatf("vec%0d dut0.rdata1", i), bus0.rdata1, vecs[i].exp1);
            check($sformatf("vec%0d dut0.rdata2", i), bus0.rdata2, vecs[i].exp2);
            check($sformatf("vec%0d dut1.rdata1", i), bus1.rdata1, vecs[i].exp1);
            check($sformatf("vec%0d dut1.rdata2", i), bus1.rdata2, vecs[i].exp2);
        end

        // Async reset between edges, writes ignored during reset, then recovery.
        @(negedge clk);
        drive(1'b1, 5'd10, 32'h12345678, 5'd10, 5'd3);
        tick();
        we = 1'b0;
        #1 check("pre-reset x10", bus0.rdata1, 32'h12345678);
        @(negedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        check("async reset x10 dut0", bus0.rdata1, 32'd0);
        check("async reset x10 dut1", bus1.rdata1, 32'd0);
        check("async reset x3 dut0", bus0.rdata2, 32'd0);
        drive(1'b1, 5'd10, 32'hCAFEF00D, 5'd10, 5'd10);
        tick();
        #1 check_all("write during reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd10, 32'd9, 5'd10, 5'd0);
        tick();
        we = 1'b0;
        #1;
        check("post-reset x10 dut0", bus0.rdata1, 32'd9);
        check("post-reset x10 dut1", bus1.rdata1, 32'd9);

        // Read-during-write on the same address.
        @(negedge clk);
        drive(1'b1, 5'd4, 32'd1, 5'd4, 5'd0);
        tick();
        @(negedge clk);
        drive(1'b1, 5'd4, 32'd2, 5'd4, 5'd4);
        #1;
        check("rdw before edge dut0", bus0.rdata1, 32'd1);
        check("rdw before edge dut1", bus1.rdata1, 32'd2);
        tick();
        we = 1'b0;
        #1;
        check("rdw after edge dut0", bus0.rdata1, 32'd2);
        check("rdw after edge dut1", bus1.rdata1, 32'd2);

        // Bypass never exposes x0.
        @(negedge clk);
        drive(1'b1, 5'd0, 32'h55AA55AA, 5'd0, 5'd0);
        #1;
        check("x0 bypass dut1 r1", bus1.rdata1, 32'd0);
        check("x0 bypass dut1 r2", bus1.rdata2, 32'd0);
        tick();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 40) != 0);
            if (!rst_n) clear_model();
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                  AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) raddr1 = waddr;
            #1 check_all($sformatf("rand%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
